// File: rtl/commit_retire.sv
// rtl/commit_retire.sv - in-order commit-station ring tracker with bounded-width retirement
// Purpose: tracks which commit stations are allocated and completed, retires the
//   completed prefix from the ring head (up to NRETIRE per clock), and handles
//   mispredict truncation and full flush.
// Ports:
//   i_clk, i_reset (sync, active-low)
//   i_alloc_count   stations allocated this cycle starting at o_next_start
//   i_done_set      per-station completion strobes
//   i_flush_valid / i_flush_addr  keep up to and including i_flush_addr, drop younger
//   i_flush_all     drop every unretired station
//   o_next_start    ring tail (next allocation index)
//   o_current_end   ring head (oldest unretired station)
//   o_current_available  free stations
//   o_commit_reg / o_retire_count  stations retiring this cycle and their count
//   o_commit_done   valid and completed, not yet retired (registered view)
//   o_alloc_err     one-cycle pulse after a dropped allocation
module commit_retire #(
  parameter int NCOMMIT  = 32,
  parameter int LNCOMMIT = 5,
  parameter int NRETIRE  = 8,
  parameter int NALLOC   = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [LNCOMMIT-1:0] i_alloc_count,
  input  logic [NCOMMIT-1:0]  i_done_set,
  input  logic                i_flush_valid,
  input  logic [LNCOMMIT-1:0] i_flush_addr,
  input  logic                i_flush_all,
  output logic [LNCOMMIT-1:0] o_next_start,
  output logic [LNCOMMIT-1:0] o_current_end,
  output logic [LNCOMMIT:0]   o_current_available,
  output logic [NCOMMIT-1:0]  o_commit_reg,
  output logic [NCOMMIT-1:0]  o_commit_done,
  output logic [LNCOMMIT:0]   o_retire_count,
  output logic                o_alloc_err
);

  localparam logic [LNCOMMIT:0]   C_NCOMMIT = (LNCOMMIT+1)'(NCOMMIT);
  localparam logic [LNCOMMIT:0]   C_NALLOC  = (LNCOMMIT+1)'(NALLOC);
  localparam logic [LNCOMMIT:0]   C_ONE_W   = (LNCOMMIT+1)'(1);
  localparam logic [LNCOMMIT-1:0] C_ONE     = LNCOMMIT'(1);

  logic [LNCOMMIT-1:0] r_head;
  logic [LNCOMMIT-1:0] r_tail;
  logic [LNCOMMIT:0]   r_count;
  logic [NCOMMIT-1:0]  r_valid;
  logic [NCOMMIT-1:0]  r_done;
  logic                r_alloc_err;

  logic [LNCOMMIT:0]   w_avail;
  logic [LNCOMMIT-1:0] w_flush_age;
  logic                w_flush_ok;
  logic                w_alloc_fits;
  logic                w_alloc_ok;
  logic                w_alloc_bad;
  logic [LNCOMMIT:0]   w_scan_lim;
  logic [NCOMMIT-1:0]  w_commit;
  logic [LNCOMMIT:0]   w_retire_cnt;
  logic [NCOMMIT-1:0]  w_valid_nxt;
  logic [NCOMMIT-1:0]  w_done_nxt;
  logic [LNCOMMIT:0]   w_count_nxt;
  logic [LNCOMMIT-1:0] w_tail_nxt;

  assign w_avail     = C_NCOMMIT - r_count;
  // Distance of the flush point from the head; the flush keeps w_flush_age+1 stations.
  assign w_flush_age = i_flush_addr - r_head;
  // A flush naming an unallocated station is meaningless and is dropped.
  assign w_flush_ok  = i_flush_valid & ~i_flush_all & r_valid[i_flush_addr];

  // Allocation is judged against registered occupancy; same-cycle retirement
  // frees space only for the following cycle.
  assign w_alloc_fits = ({1'b0, i_alloc_count} <= w_avail) &&
                        ({1'b0, i_alloc_count} <= C_NALLOC);
  assign w_alloc_ok   = ~i_flush_all & ~w_flush_ok & w_alloc_fits;
  assign w_alloc_bad  = ~i_flush_all & ~w_flush_ok & ~w_alloc_fits;

  // Retire scan: contiguous valid&done run from the head. During a mispredict
  // flush the scan never passes the flush point, so wrong-path stations that
  // happen to be done are discarded rather than retired.
  always_comb begin : retire_scan
    logic                stop;
    logic [LNCOMMIT-1:0] idx;
    w_commit     = '0;
    w_retire_cnt = '0;
    stop         = 1'b0;
    idx          = '0;
    w_scan_lim   = r_count;
    if (w_flush_ok && (({1'b0, w_flush_age} + C_ONE_W) < w_scan_lim)) begin
      w_scan_lim = {1'b0, w_flush_age} + C_ONE_W;
    end
    for (int k = 0; k < NRETIRE; k++) begin
      idx = r_head + LNCOMMIT'(k);
      if (!stop && ((LNCOMMIT+1)'(k) < w_scan_lim) && r_valid[idx] && r_done[idx]) begin
        w_commit[idx] = 1'b1;
        w_retire_cnt  = w_retire_cnt + C_ONE_W;
      end else begin
        stop = 1'b1;
      end
    end
    if (i_flush_all) begin
      w_commit     = '0;
      w_retire_cnt = '0;
    end
  end

  // Per-station next state. Allocation is applied last so it overrides any
  // completion strobe aimed at the same station.
  always_comb begin : station_next
    logic [LNCOMMIT-1:0] age;
    logic [LNCOMMIT-1:0] off;
    age         = '0;
    off         = '0;
    w_valid_nxt = r_valid & ~w_commit;
    w_done_nxt  = (r_done | (i_done_set & r_valid)) & ~w_commit;
    for (int i = 0; i < NCOMMIT; i++) begin
      age = LNCOMMIT'(i) - r_head;
      off = LNCOMMIT'(i) - r_tail;
      if (w_flush_ok && (age > w_flush_age)) begin
        w_valid_nxt[i] = 1'b0;
        w_done_nxt[i]  = 1'b0;
      end
      if (w_alloc_ok && (off < i_alloc_count)) begin
        w_valid_nxt[i] = 1'b1;
        w_done_nxt[i]  = 1'b0;
      end
    end
  end

  always_comb begin
    w_count_nxt = r_count - w_retire_cnt;
    w_tail_nxt  = r_tail;
    if (w_flush_ok) begin
      w_count_nxt = {1'b0, w_flush_age} + C_ONE_W - w_retire_cnt;
      w_tail_nxt  = i_flush_addr + C_ONE;
    end else if (w_alloc_ok) begin
      w_count_nxt = r_count + {1'b0, i_alloc_count} - w_retire_cnt;
      w_tail_nxt  = r_tail + i_alloc_count;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_valid     <= '0;
      r_done      <= '0;
      r_alloc_err <= 1'b0;
    end else if (i_flush_all) begin
      // Everything unretired is discarded; the ring restarts empty at the tail.
      r_head      <= r_tail;
      r_count     <= '0;
      r_valid     <= '0;
      r_done      <= '0;
      r_alloc_err <= 1'b0;
    end else begin
      r_head      <= r_head + w_retire_cnt[LNCOMMIT-1:0];
      r_tail      <= w_tail_nxt;
      r_count     <= w_count_nxt;
      r_valid     <= w_valid_nxt;
      r_done      <= w_done_nxt;
      r_alloc_err <= w_alloc_bad;
    end
  end

  assign o_next_start        = r_tail;
  assign o_current_end       = r_head;
  assign o_current_available = w_avail;
  assign o_commit_reg        = w_commit;
  assign o_retire_count      = w_retire_cnt;
  assign o_commit_done       = r_valid & r_done;
  assign o_alloc_err         = r_alloc_err;

endmodule
